// File: rtl/sc_multiplier.sv
// Stochastic-computing multiplier: compares latched operands against LFSR randoms,
// ANDs the two unipolar streams and counts ones over LEN cycles.
module sc_multiplier #(
  parameter int LEN   = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [7:0]       n1,
  input  logic [7:0]       n2,
  output logic             seed_set,
  output logic             busy,
  output logic             done,
  output logic             sc_bit,
  output logic [CNT_W-1:0] product
);

  typedef enum logic [2:0] {IDLE, SEED, PRIME, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(LEN - 1);

  state_t           state;
  state_t           state_next;
  logic [7:0]       a_r;
  logic [7:0]       b_r;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] cyc;
  logic             run_bit;
  logic             last_cyc;
  logic [CNT_W-1:0] acc_next;

  assign run_bit  = (n1 < a_r) && (n2 < b_r);
  assign last_cyc = (cyc == LAST_CYC);
  assign acc_next = acc + CNT_W'(run_bit);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SEED;
      end
      SEED: begin
        busy       = 1'b1;
        state_next = PRIME;
      end
      PRIME: begin
        busy       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_cyc) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // seed_set is registered so the LFSR sees it for exactly the SEED cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      seed_set <= 1'b0;
      sc_bit   <= 1'b0;
      product  <= '0;
      acc      <= '0;
      cyc      <= '0;
      a_r      <= '0;
      b_r      <= '0;
    end else begin
      state    <= state_next;
      seed_set <= (state == IDLE) && start;
      if (state == IDLE && start) begin
        a_r <= a;
        b_r <= b;
        acc <= '0;
        cyc <= '0;
      end
      if (state == RUN) begin
        acc    <= acc_next;
        cyc    <= cyc + 1'b1;
        sc_bit <= run_bit;
        if (last_cyc) product <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_sc_multiplier.sv
// Bench for sc_multiplier: drives a counter or LFSR random source and checks
// products, timing and control behaviour against an arithmetic reference.
module tb_sc_multiplier;

  localparam int          LEN   = 256;
  localparam int          CNT_W = 9;
  localparam logic [15:0] SEED  = 16'd14472;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [7:0]       n1;
  logic [7:0]       n2;
  logic             seed_set;
  logic             busy;
  logic             done;
  logic             sc_bit;
  logic [CNT_W-1:0] product;

  int          tests = 0;
  int          fails = 0;
  bit          use_lfsr;
  logic [15:0] src;

  sc_multiplier #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .n1(n1), .n2(n2),
    .seed_set(seed_set), .busy(busy), .done(done), .sc_bit(sc_bit), .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Expected ones count: stream cycle r sees the r-th source value after seeding
  function automatic int modelProduct(input int ai, input int bi, input bit lfsr_mode);
    logic [15:0] v;
    int cnt;
    int x1;
    int x2;
    v   = SEED;
    cnt = 0;
    for (int r = 0; r < LEN; r++) begin
      if (lfsr_mode) begin
        x1 = int'(v[7:0]);
        x2 = int'(v[15:8]);
        v  = lfsrStep(v);
      end else begin
        x1 = r % 256;
        x2 = r % 256;
      end
      if (x1 < ai && x2 < bi) cnt++;
    end
    return cnt;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests++;
    if (observed != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock; the random source is a registered block reseeded by seed_set
  task automatic tick();
    logic        ss;
    logic [15:0] old;
    ss = seed_set;
    @(posedge clk);
    #1;
    old = src;
    if (use_lfsr) begin
      n1  = old[7:0];
      n2  = old[15:8];
      src = ss ? SEED : lfsrStep(old);
    end else begin
      n1  = old[7:0];
      n2  = old[7:0];
      src = ss ? 16'd0 : old + 16'd1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ai, input logic [7:0] bi,
                               input int pulse_run, input int reset_run, input bit pulse_done,
                               output int lat, output int prod, output int seeds,
                               output int busy_cnt, output int done_cnt, output int ones,
                               output int idle_busy, output int post_rst);
    start = 1'b1;
    a     = ai;
    b     = bi;
    tick();
    lat = -1; prod = -1; seeds = 0; busy_cnt = 0; done_cnt = 0;
    ones = 0; idle_busy = 0; post_rst = -1;
    for (int k = 0; k <= LEN + 4; k++) begin
      seeds    += int'(seed_set);
      busy_cnt += int'(busy);
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat  = k;
          prod = int'(product);
        end
      end
      if (k >= 3 && k <= LEN + 2) ones += int'(sc_bit);
      if (k >= LEN + 3) idle_busy += int'(busy);
      if (reset_run >= 0 && k == reset_run + 3)
        post_rst = int'(product) + int'(busy) + int'(done) + int'(seed_set) + int'(sc_bit);
      start = 1'b0;
      rst   = 1'b0;
      a     = ai;
      b     = bi;
      if (pulse_run >= 0 && k == pulse_run + 2) begin
        start = 1'b1; a = ~ai; b = ~bi;
      end
      if (pulse_done && done) begin
        start = 1'b1; a = ~ai; b = ~bi;
      end
      if (reset_run >= 0 && k == reset_run + 2) rst = 1'b1;
      if (k < LEN + 4) tick();
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                             input int pulse_run, input bit pulse_done, output int prod);
    int lat, seeds, busy_cnt, done_cnt, ones, idle_busy, post_rst, exp_p;
    applyStimulus(ai, bi, pulse_run, -1, pulse_done,
                  lat, prod, seeds, busy_cnt, done_cnt, ones, idle_busy, post_rst);
    exp_p = modelProduct(int'(ai), int'(bi), use_lfsr);
    checkOutput({tag, "_product"}, prod, exp_p);
    checkOutput({tag, "_latency"}, lat, LEN + 2);
    checkOutput({tag, "_seed_cycles"}, seeds, 1);
    checkOutput({tag, "_busy_cycles"}, busy_cnt, LEN + 2);
    checkOutput({tag, "_done_pulses"}, done_cnt, 1);
    checkOutput({tag, "_sc_bit_ones"}, ones, exp_p);
    checkOutput({tag, "_idle_after"}, idle_busy, 0);
  endtask

  task automatic backToBack();
    logic [7:0] al [3];
    logic [7:0] bl [3];
    int idx;
    int prev;
    al = '{8'd100, 8'd37, 8'd255};
    bl = '{8'd200, 8'd250, 8'd255};
    idx   = 0;
    prev  = -1;
    start = 1'b1;
    a     = al[0];
    b     = bl[0];
    tick();
    for (int k = 0; k < 3 * (LEN + 4) + 8 && idx < 3; k++) begin
      if (done) begin
        checkOutput($sformatf("b2b%0d_product", idx), int'(product),
                    modelProduct(int'(al[idx]), int'(bl[idx]), 1'b0));
        if (idx == 0) checkOutput("b2b0_latency", k, LEN + 2);
        else          checkOutput($sformatf("b2b%0d_spacing", idx), k - prev, LEN + 4);
        prev = k;
        idx++;
        if (idx < 3) begin
          a = al[idx];
          b = bl[idx];
        end else begin
          start = 1'b0;
        end
      end
      if (idx < 3) tick();
    end
    start = 1'b0;
    checkOutput("b2b_runs", idx, 3);
    repeat (4) tick();
    checkOutput("b2b_idle_after", int'(busy), 0);
  endtask

  initial begin
    int ss_cnt, prod, prod_a, prod_b;
    int lat, seeds, busy_cnt, done_cnt, ones, idle_busy, post_rst;
    logic [7:0] ra, rb;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; n1 = '0; n2 = '0;
    src = '0; use_lfsr = 1'b0;

    rst    = 1'b1;
    start  = 1'b1;
    a      = 8'($urandom);
    b      = 8'($urandom);
    ss_cnt = 0;
    repeat (2) begin
      tick();
      ss_cnt += int'(seed_set);
    end
    checkOutput("reset_seed_set", ss_cnt, 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_sc_bit", int'(sc_bit), 0);
    checkOutput("reset_product", int'(product), 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("reset_stays_idle", int'(busy), 0);

    runAndCheck("cnt_100_200", 8'd100, 8'd200, -1, 1'b0, prod);
    checkOutput("cnt_100_200_const", prod, 100);
    runAndCheck("cnt_255_255", 8'd255, 8'd255, -1, 1'b0, prod);
    checkOutput("cnt_255_255_const", prod, 255);
    runAndCheck("cnt_0_77", 8'd0, 8'd77, -1, 1'b0, prod);
    checkOutput("cnt_0_77_const", prod, 0);

    runAndCheck("ignored_start", 8'd100, 8'd200, 50, 1'b1, prod);
    checkOutput("ignored_start_const", prod, 100);

    applyStimulus(8'd100, 8'd200, -1, 100, 1'b0,
                  lat, prod, seeds, busy_cnt, done_cnt, ones, idle_busy, post_rst);
    checkOutput("midrst_outputs_zero", post_rst, 0);
    checkOutput("midrst_no_done", done_cnt, 0);
    checkOutput("midrst_idle_after", idle_busy, 0);
    runAndCheck("after_midrst", 8'd100, 8'd200, -1, 1'b0, prod);
    checkOutput("after_midrst_const", prod, 100);

    use_lfsr = 1'b1;
    runAndCheck("lfsr_run1", 8'd128, 8'd128, -1, 1'b0, prod_a);
    runAndCheck("lfsr_run2", 8'd128, 8'd128, -1, 1'b0, prod_b);
    checkOutput("lfsr_repeatable", prod_b, prod_a);

    for (int i = 0; i < 4; i++) begin
      use_lfsr = 1'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      runAndCheck($sformatf("rand%0d", i), ra, rb, -1, 1'b0, prod);
    end

    use_lfsr = 1'b0;
    backToBack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sc_multiplier.md
# sc_multiplier

Stochastic-computing multiply stage sitting directly downstream of the 16-bit LFSR random source in the inference engine. It owns the LFSR's `seed_set` line and consumes its two 8-bit random numbers `n1`/`n2`. Each product runs the same deterministic sequence: it converts two latched 8-bit operands (pixel, weight) into unipolar bitstreams by comparison against `n1`/`n2`, ANDs the streams and counts ones over `LEN` cycles. The result is `product ≈ a*b*LEN/65536`, which the neuron accumulator consumes.

## Interface
Parameters:
- `LEN`, 256, stream length in cycles; legal range 1 .. 2^CNT_W−1.
- `CNT_W`, 9, width of the ones counter, the cycle counter and `product`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request a product. Sampled only in IDLE.
- `a` input 8: operand A (pixel), unsigned. Latched on accepted `start`.
- `b` input 8: operand B (weight), unsigned. Latched on accepted `start`.
- `n1` input 8: random number 1, from the LFSR.
- `n2` input 8: random number 2, from the LFSR.
- `seed_set` output 1: drives the LFSR `seed_set`. Registered.
- `busy` output 1: high in SEED, PRIME and RUN.
- `done` output 1: one-cycle pulse; `product` is valid from this cycle on.
- `sc_bit` output 1: current AND-stream bit. Registered; debug only.
- `product` output CNT_W: count of ones in the AND stream. Holds until the next completion.

## Operation
- States: IDLE, SEED, PRIME, RUN, DONE.
- **IDLE**
  - `busy=0`, `seed_set=0`.
  - On `start=1`: latch `a_r<=a`, `b_r<=b`, clear `acc` and `cyc`, go to SEED.
- **SEED** (1 cycle)
  - `seed_set=1`, so the LFSR loads its fixed seed at the next edge.
  - Go to PRIME.
- **PRIME** (1 cycle)
  - `seed_set=0`.
  - `n1`/`n2` are stale this cycle and are ignored; the LFSR registers its first seeded outputs at the end of this cycle.
  - Go to RUN.
- **RUN** (exactly LEN cycles)
  - Each cycle: `bit = (n1 < a_r) & (n2 < b_r)`, unsigned 8-bit compare.
  - `acc <= acc + bit`, `cyc <= cyc + 1`, `sc_bit <= bit`.
  - On the cycle with `cyc == LEN−1`: `product <= acc + bit` and go to DONE.
- **DONE** (1 cycle)
  - `done=1`, `busy=0`.
  - Go to IDLE.
  - A `start` in DONE is ignored. The earliest accepted `start` is the following IDLE cycle.
- `start` during SEED, PRIME, RUN or DONE is ignored; it is not queued.
- Operands change only on an accepted `start`.
- Because every run reseeds the LFSR, identical (a, b) produce an identical `product`.
- Arithmetic:
  - `acc` is CNT_W bits and can never overflow, since the maximum value is LEN ≤ 2^CNT_W−1.
  - `a=0` or `b=0` forces `bit=0`.
  - `a=255` still gives `bit=0` whenever `n1==255`.

## Timing
- Reset values: state IDLE, `seed_set=0`, `busy=0`, `done=0`, `sc_bit=0`, `product=0`, `acc=0`, `cyc=0`, `a_r=0`, `b_r=0`.
- `rst` mid-operation returns to IDLE at the next edge with all of the above values.
  - No `done` pulse is produced.
  - `product` is cleared to 0.
- Latency: `start` sampled at edge E0.
  - `seed_set` is high in the cycle after E0.
  - RUN covers the cycles after edges E2 .. E(LEN+1).
  - `done` and the new `product` appear after edge E(LEN+2).
  - Total: LEN+2 cycles from the sampling edge to `done`.
  - `busy` is high for exactly LEN+2 cycles.
- Throughput: one product per LEN+4 cycles when `start` is held high (IDLE → … → DONE → IDLE).
- `rst` and `start` high together: reset wins.

## Test plan
- **Reset:** assert `rst` 2 cycles with `start=1` → all outputs 0, state IDLE, `seed_set` never pulses.
- **Bench-driven counter source:** replace the LFSR with a bench driving `n1 = n2 = i`, where i = 0..255 increments from the first RUN cycle. LEN=256.
  - `a=100, b=200` → `product=100`.
  - `a=255, b=255` → `product=255`.
  - `a=0, b=77` → `product=0`.
  - In each case `done` pulses exactly 258 cycles after the `start` edge.
- **Real LFSR attached:** `a=128, b=128`, run twice → both results bit-identical and equal to the golden model (LFSR seed 14472 with the discarded prime cycle). `seed_set` is high exactly one cycle per run.
- **Ignored start:** pulse `start` with new operands at RUN cycle 50 and again in DONE → result unchanged, no extra run, `busy` drops after `done`.
- **Reset mid-run:** assert `rst` at RUN cycle 100 → next cycle IDLE, `product=0`, no `done`. A following `start` with `a=100, b=200` (counter source) → `product=100`.
- **Back-to-back:** `start` held high for 3 runs → `done` pulses spaced LEN+4 cycles apart, each with the correct `product`.
